// File: rtl/exu_oitf_pkg.sv
// Shared sizing for the long-pipe outstanding instruction track FIFO.
package exu_oitf_pkg;
   localparam int OITF_DEPTH  = 4;
   localparam int ITAG_WIDTH  = $clog2(OITF_DEPTH);
   localparam int RFIDX_WIDTH = 5;
endpackage

// File: rtl/exu_oitf_ptr.sv
// Circular pointer with wrap flag; the flag distinguishes full from empty.
module exu_oitf_ptr #(
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr,
   output logic             flg
);
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             flg_q, flg_d;

   // Depth is a power of two, so natural overflow is the wrap.
   always_comb begin
      ptr_d = ptr_q;
      flg_d = flg_q;
      if (inc) begin
         ptr_d = ptr_q + PTR_W'(1);
         flg_d = flg_q ^ (&ptr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         flg_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         flg_q <= flg_d;
      end
   end

   assign ptr = ptr_q;
   assign flg = flg_q;
endmodule

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO: in-order alloc/retire of long-pipe itags
// plus RAW/WAW hazard detection against every in-flight entry.
module exu_oitf
   import exu_oitf_pkg::*;
#(
   parameter int DEPTH = OITF_DEPTH,
   parameter int PTR_W = ITAG_WIDTH,
   parameter int RF_W  = RFIDX_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dis_ena,
   output logic             dis_ready,
   output logic [PTR_W-1:0] dis_ptr,
   input  logic             disp_i_rdwen,
   input  logic [RF_W-1:0]  disp_i_rdidx,
   input  logic             disp_i_rs1en,
   input  logic [RF_W-1:0]  disp_i_rs1idx,
   input  logic             disp_i_rs2en,
   input  logic [RF_W-1:0]  disp_i_rs2idx,
   output logic             oitfrd_match_disprs1,
   output logic             oitfrd_match_disprs2,
   output logic             oitfrd_match_disprd,
   input  logic             oitf_ret_ena,
   output logic [PTR_W-1:0] oitf_ret_ptr,
   output logic             oitf_ret_rdwen,
   output logic [RF_W-1:0]  oitf_ret_rdidx,
   output logic             oitf_empty,
   output logic             oitf_full
);
   logic [PTR_W-1:0] alc_ptr, ret_ptr;
   logic             alc_flg, ret_flg;
   logic             alc_ena, ret_ena;

   logic [DEPTH-1:0]           ent_vld, ent_rdwen;
   logic [DEPTH-1:0][RF_W-1:0] ent_rdidx;
   logic [DEPTH-1:0]           m_rs1, m_rs2, m_rd;

   assign oitf_empty = (alc_ptr == ret_ptr) & (alc_flg == ret_flg);
   assign oitf_full  = (alc_ptr == ret_ptr) & (alc_flg != ret_flg);
   assign alc_ena    = dis_ena & ~oitf_full;
   assign ret_ena    = oitf_ret_ena & ~oitf_empty;

   exu_oitf_ptr #(.PTR_W(PTR_W)) u_alc_ptr (
      .clk(clk), .rst_n(rst_n), .inc(alc_ena), .ptr(alc_ptr), .flg(alc_flg)
   );

   exu_oitf_ptr #(.PTR_W(PTR_W)) u_ret_ptr (
      .clk(clk), .rst_n(rst_n), .inc(ret_ena), .ptr(ret_ptr), .flg(ret_flg)
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic            vld_q, vld_d, rdwen_q, rdwen_d;
      logic [RF_W-1:0] rdidx_q, rdidx_d;
      logic            set, clr;

      // Alloc and retire never target the same slot: that needs full or empty.
      assign set = alc_ena & (alc_ptr == PTR_W'(i));
      assign clr = ret_ena & (ret_ptr == PTR_W'(i));

      always_comb begin
         vld_d   = vld_q;
         rdwen_d = rdwen_q;
         rdidx_d = rdidx_q;
         if (set) begin
            vld_d   = 1'b1;
            rdwen_d = disp_i_rdwen;
            rdidx_d = disp_i_rdidx;
         end else if (clr) begin
            vld_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q   <= 1'b0;
            rdwen_q <= 1'b0;
            rdidx_q <= '0;
         end else begin
            vld_q   <= vld_d;
            rdwen_q <= rdwen_d;
            rdidx_q <= rdidx_d;
         end
      end

      assign ent_vld[i]   = vld_q;
      assign ent_rdwen[i] = rdwen_q;
      assign ent_rdidx[i] = rdidx_q;

      // A retiring entry still matches this cycle; conservative by design.
      assign m_rs1[i] = vld_q & rdwen_q & disp_i_rs1en & (rdidx_q == disp_i_rs1idx)
                        & (disp_i_rs1idx != '0);
      assign m_rs2[i] = vld_q & rdwen_q & disp_i_rs2en & (rdidx_q == disp_i_rs2idx)
                        & (disp_i_rs2idx != '0);
      assign m_rd[i]  = vld_q & rdwen_q & disp_i_rdwen & (rdidx_q == disp_i_rdidx)
                        & (disp_i_rdidx != '0);
   end

   assign oitfrd_match_disprs1 = |m_rs1;
   assign oitfrd_match_disprs2 = |m_rs2;
   assign oitfrd_match_disprd  = |m_rd;

   assign dis_ready      = ~oitf_full;
   assign dis_ptr        = alc_ptr;
   assign oitf_ret_ptr   = ret_ptr;
   assign oitf_ret_rdwen = ent_rdwen[ret_ptr] & ~oitf_empty;
   assign oitf_ret_rdidx = ent_rdidx[ret_ptr];

   logic unused_ok;
   assign unused_ok = ^ent_vld;
endmodule
